// File: rtl/spd_pkg.sv
// Shared state encoding and SPD byte list for the SPD read sequencer.
package spd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_REQ,
    SCAN_WAIT,
    READ_REQ,
    READ_WAIT,
    DONE,
    ERROR
  } spd_state_t;

  localparam int SPD_LIST_LEN = 9;
  localparam int MAX_RETRIES  = 3;

  // Entry 0 is the rightmost element: bytes 2,3,4,5,7,8,10,11,12.
  localparam logic [SPD_LIST_LEN-1:0][7:0] SPD_BYTE_LIST = {
    8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2
  };

  function automatic logic [7:0] spd_byte_at(input logic [3:0] idx);
    if (idx < 4'(SPD_LIST_LEN)) return SPD_BYTE_LIST[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/spd_timeout_ctr.sv
// Per-transaction wait counter; expired is high once TIMEOUT_CYCLES-1 cycles have elapsed.
module spd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/spd_read_sequencer.sv
// Scans I2C addresses for an SPD EEPROM, then reads the fixed SPD byte list from it.
// Build option: define SPD_SEQ_RETRY_EN to retry NACKed byte reads up to MAX_RETRIES times.
//
// state     | meaning
// IDLE      | waiting for i_start
// SCAN_REQ  | issue probe read of register 0 at probe address
// SCAN_WAIT | wait for probe transaction to finish
// READ_REQ  | issue read of current SPD list entry
// READ_WAIT | wait for byte read to finish
// DONE      | all list bytes reported
// ERROR     | no device, NACK or timeout
module spd_read_sequencer
  import spd_pkg::*;
#(
  parameter logic [6:0] SCAN_FIRST     = 7'h50,
  parameter logic [6:0] SCAN_LAST      = 7'h57,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_enable,
  output logic       o_read_write,
  output logic [7:0] o_register_address,
  output logic [6:0] o_device_address,
  input  logic [7:0] i_miso_data,
  input  logic       i_busy,
  input  logic       i_slave_nack,
  output logic [6:0] o_spd_address,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_index,
  output logic [7:0] o_byte_data,
  output logic       o_done,
  output logic       o_error
);

  localparam logic [3:0] LAST_IDX = 4'(SPD_LIST_LEN - 1);

  spd_state_t state;
  logic [6:0] probe_addr;
  logic [3:0] list_idx;
  logic       busy_seen;
  logic       wait_cmplt;
  logic       tmo_clear;
  logic       tmo_en;
  logic       tmo_expired;

`ifdef SPD_SEQ_RETRY_EN
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);
  logic [1:0] retry_cnt;
`endif

  // A wait only completes on a busy high-then-low sequence seen after entry.
  assign wait_cmplt = busy_seen && !i_busy;
  assign tmo_clear  = ((state == SCAN_REQ) || (state == READ_REQ)) && !i_busy;
  assign tmo_en     = (state == SCAN_WAIT) || (state == READ_WAIT);

  spd_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      probe_addr         <= 7'h00;
      list_idx           <= 4'd0;
      busy_seen          <= 1'b0;
      o_enable           <= 1'b0;
      o_read_write       <= 1'b0;
      o_register_address <= 8'h00;
      o_device_address   <= 7'h00;
      o_spd_address      <= 7'h00;
      o_byte_valid       <= 1'b0;
      o_byte_index       <= 8'h00;
      o_byte_data        <= 8'h00;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
`ifdef SPD_SEQ_RETRY_EN
      retry_cnt          <= 2'd0;
`endif
    end else begin
      o_enable     <= 1'b0;
      o_byte_valid <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            probe_addr <= SCAN_FIRST;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            state      <= SCAN_REQ;
          end
        end
        SCAN_REQ: begin
          o_read_write       <= 1'b1;
          o_register_address <= 8'h00;
          o_device_address   <= probe_addr;
          if (!i_busy) begin
            o_enable  <= 1'b1;
            busy_seen <= 1'b0;
            state     <= SCAN_WAIT;
          end
        end
        SCAN_WAIT: begin
          if (i_busy) busy_seen <= 1'b1;
          if (wait_cmplt) begin
            if (!i_slave_nack) begin
              o_spd_address <= probe_addr;
              list_idx      <= 4'd0;
`ifdef SPD_SEQ_RETRY_EN
              retry_cnt     <= 2'd0;
`endif
              state         <= READ_REQ;
            end else if (probe_addr < SCAN_LAST) begin
              probe_addr <= probe_addr + 7'd1;
              state      <= SCAN_REQ;
            end else begin
              o_error <= 1'b1;
              o_done  <= 1'b0;
              state   <= ERROR;
            end
          end else if (tmo_expired) begin
            o_error <= 1'b1;
            o_done  <= 1'b0;
            state   <= ERROR;
          end
        end
        READ_REQ: begin
          o_read_write       <= 1'b1;
          o_register_address <= spd_byte_at(list_idx);
          o_device_address   <= o_spd_address;
          if (!i_busy) begin
            o_enable  <= 1'b1;
            busy_seen <= 1'b0;
            state     <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (i_busy) busy_seen <= 1'b1;
          if (wait_cmplt) begin
            if (i_slave_nack) begin
`ifdef SPD_SEQ_RETRY_EN
              if (retry_cnt < RETRY_LIMIT) begin
                retry_cnt <= retry_cnt + 2'd1;
                state     <= READ_REQ;
              end else begin
                o_error <= 1'b1;
                o_done  <= 1'b0;
                state   <= ERROR;
              end
`else
              o_error <= 1'b1;
              o_done  <= 1'b0;
              state   <= ERROR;
`endif
            end else begin
              o_byte_valid <= 1'b1;
              o_byte_data  <= i_miso_data;
              o_byte_index <= spd_byte_at(list_idx);
              list_idx     <= list_idx + 4'd1;
`ifdef SPD_SEQ_RETRY_EN
              retry_cnt    <= 2'd0;
`endif
              if (list_idx == LAST_IDX) begin
                o_done <= 1'b1;
                state  <= DONE;
              end else begin
                state <= READ_REQ;
              end
            end
          end else if (tmo_expired) begin
            o_error <= 1'b1;
            o_done  <= 1'b0;
            state   <= ERROR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spd_read_sequencer.sv
// Directed bench for spd_read_sequencer with a small reactive I2C master model.
module tb_spd_read_sequencer;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       o_enable;
  logic       o_read_write;
  logic [7:0] o_register_address;
  logic [6:0] o_device_address;
  logic [7:0] i_miso_data;
  logic       i_busy;
  logic       i_slave_nack;
  logic [6:0] o_spd_address;
  logic       o_byte_valid;
  logic [7:0] o_byte_index;
  logic [7:0] o_byte_data;
  logic       o_done;
  logic       o_error;

  spd_read_sequencer #(
    .SCAN_FIRST    (7'h50),
    .SCAN_LAST     (7'h57),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .o_enable          (o_enable),
    .o_read_write      (o_read_write),
    .o_register_address(o_register_address),
    .o_device_address  (o_device_address),
    .i_miso_data       (i_miso_data),
    .i_busy            (i_busy),
    .i_slave_nack      (i_slave_nack),
    .o_spd_address     (o_spd_address),
    .o_byte_valid      (o_byte_valid),
    .o_byte_index      (o_byte_index),
    .o_byte_data       (o_byte_data),
    .o_done            (o_done),
    .o_error           (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] ack_addr = 7'h52;
  bit         ack_none = 1'b0;
  bit         mute = 1'b0;
  bit         nack_pending = 1'b0;
  logic [7:0] nack_reg = 8'h00;
  int         mcnt = 0;
  logic [6:0] probes[$];
  logic [7:0] bidx[$];
  logic [7:0] bdat[$];
  int         exp_idx[9] = '{2, 3, 4, 5, 7, 8, 10, 11, 12};

  // Master model: busy for three cycles after each enable; read data is register ^ 8'hA0.
  always @(negedge i_clk) begin
    if (i_rst) begin
      i_busy       = 1'b0;
      i_slave_nack = 1'b0;
      mcnt         = 0;
    end else if (mcnt != 0) begin
      mcnt--;
      if (mcnt == 0) i_busy = 1'b0;
    end else if (o_enable) begin
      if (o_register_address == 8'h00) begin
        probes.push_back(o_device_address);
        i_slave_nack = ack_none || (o_device_address != ack_addr);
      end else begin
        i_slave_nack = nack_pending && (o_register_address == nack_reg);
        if (i_slave_nack) nack_pending = 1'b0;
        i_miso_data = o_register_address ^ 8'hA0;
      end
      if (!mute) begin
        i_busy = 1'b1;
        mcnt   = 3;
      end
    end
    if (o_byte_valid) begin
      bidx.push_back(o_byte_index);
      bdat.push_back(o_byte_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    probes.delete();
    bidx.delete();
    bdat.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(o_done || o_error) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, 32'(o_done || o_error), 32'd1);
    @(negedge i_clk);
  endtask

  task automatic wait_en(input string tag, input bit want_read);
    int n = 0;
    while (!(o_enable && (!want_read || o_register_address != 8'h00)) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, 32'(o_enable), 32'd1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_enable"}, 32'(o_enable), 32'd0);
    check({pfx, "_rw"}, 32'(o_read_write), 32'd0);
    check({pfx, "_reg"}, 32'(o_register_address), 32'h00);
    check({pfx, "_dev"}, 32'(o_device_address), 32'h00);
    check({pfx, "_spd"}, 32'(o_spd_address), 32'h00);
    check({pfx, "_valid"}, 32'(o_byte_valid), 32'd0);
    check({pfx, "_index"}, 32'(o_byte_index), 32'h00);
    check({pfx, "_data"}, 32'(o_byte_data), 32'h00);
    check({pfx, "_done"}, 32'(o_done), 32'd0);
    check({pfx, "_error"}, 32'(o_error), 32'd0);
  endtask

  initial begin
    int n;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_miso_data = 8'h00;
    i_busy = 1'b0;
    i_slave_nack = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset("rst");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Device at 0x52: three probes, then nine bytes.
    ack_addr = 7'h52;
    clear_logs();
    pulse_start();
    wait_end("a_end");
    check("a_nprobe", probes.size(), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("a_probe%0d", i), 32'(probes[i]), 32'h50 + 32'(i));
    check("a_spd", 32'(o_spd_address), 32'h52);
    check("a_nbytes", bidx.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("a_idx%0d", i), 32'(bidx[i]), 32'(exp_idx[i]));
      check($sformatf("a_dat%0d", i), 32'(bdat[i]), 32'(exp_idx[i]) ^ 32'hA0);
    end
    check("a_done", 32'(o_done), 32'd1);
    check("a_error", 32'(o_error), 32'd0);

    // Nobody answers: all eight addresses probed, then error.
    ack_none = 1'b1;
    clear_logs();
    pulse_start();
    wait_end("b_end");
    check("b_nprobe", probes.size(), 32'd8);
    check("b_first", 32'(probes[0]), 32'h50);
    check("b_last", 32'(probes[7]), 32'h57);
    check("b_error", 32'(o_error), 32'd1);
    check("b_done", 32'(o_done), 32'd0);
    check("b_nbytes", bidx.size(), 32'd0);

    // Start pulsed during SCAN_WAIT must not restart the scan.
    ack_none = 1'b0;
    ack_addr = 7'h53;
    clear_logs();
    pulse_start();
    wait_en("c_en", 1'b0);
    pulse_start();
    wait_end("c_end");
    check("c_nprobe", probes.size(), 32'd4);
    check("c_last", 32'(probes[3]), 32'h53);
    check("c_spd", 32'(o_spd_address), 32'h53);
    check("c_done", 32'(o_done), 32'd1);

    // Single NACK on byte 4.
    ack_addr = 7'h50;
    nack_reg = 8'd4;
    nack_pending = 1'b1;
    clear_logs();
    pulse_start();
    wait_end("d_end");
`ifdef SPD_SEQ_RETRY_EN
    check("d_done", 32'(o_done), 32'd1);
    check("d_error", 32'(o_error), 32'd0);
    check("d_nbytes", bidx.size(), 32'd9);
    check("d_idx2", 32'(bidx[2]), 32'd4);
    check("d_dat2", 32'(bdat[2]), 32'hA4);
`else
    check("d_done", 32'(o_done), 32'd0);
    check("d_error", 32'(o_error), 32'd1);
    check("d_nbytes", bidx.size(), 32'd2);
    check("d_idx1", 32'(bidx[1]), 32'd3);
`endif
    nack_pending = 1'b0;

    // Silent master: timeout exactly 100 cycles after WAIT entry.
    mute = 1'b1;
    clear_logs();
    pulse_start();
    wait_en("e_en", 1'b0);
    n = 0;
    while (!o_error && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check("e_cycles", 32'(n), 32'd100);
    check("e_error", 32'(o_error), 32'd1);
    check("e_done", 32'(o_done), 32'd0);
    mute = 1'b0;

    // Reset in the middle of READ_WAIT, then restart.
    ack_addr = 7'h51;
    clear_logs();
    pulse_start();
    wait_en("f_rd_en", 1'b1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset("f_rst");
    @(negedge i_clk);
    check("f_noen", 32'(o_enable), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    clear_logs();
    pulse_start();
    wait_end("f_end");
    check("f_first", 32'(probes[0]), 32'h50);
    check("f_spd", 32'(o_spd_address), 32'h51);
    check("f_nbytes", bidx.size(), 32'd9);
    check("f_done", 32'(o_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spd_read_sequencer.md
SPD_READ_SEQUENCER -- requirements
Module: spd_read_sequencer

Interface
REQ-001 SHALL have parameter SCAN_FIRST, default 7'h50, which is the first I2C device address probed.
REQ-002 SHALL have parameter SCAN_LAST, default 7'h57, which is the last I2C device address probed (SCAN_LAST >= SCAN_FIRST).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000, which is the maximum number of i_clk cycles spent waiting on one transaction.
REQ-004 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that starts the scan-and-read sequence.
- o_enable  out  1  i2c_master enable.
- o_read_write  out  1  i2c_master direction; 1 = read.
- o_register_address  out  8  i2c_master register address.
- o_device_address  out  7  i2c_master device address.
- i_miso_data  in  8  i2c_master read data.
- i_busy  in  1  i2c_master busy.
- i_slave_nack  in  1  i2c_master NACK flag.
- o_spd_address  out  7  SPD address that acknowledged.
- o_byte_valid  out  1  one-cycle pulse qualifying o_byte_index and o_byte_data.
- o_byte_index  out  8  SPD byte number just read.
- o_byte_data  out  8  SPD byte value just read.
- o_done  out  1  level; sequence completed.
- o_error  out  1  level; sequence failed.

Function
REQ-005 SHALL implement the states IDLE, SCAN_REQ, SCAN_WAIT, READ_REQ, READ_WAIT, DONE and ERROR.
REQ-006 SHALL leave IDLE, DONE or ERROR for SCAN_REQ on i_start; on that edge it loads the probe address SCAN_FIRST and clears o_done and o_error. i_start SHALL be ignored in every other state.
REQ-007 In SCAN_REQ and READ_REQ, when i_busy=0, the block SHALL assert o_enable for exactly one cycle and move to the matching WAIT state. It SHALL hold o_read_write=1 for every transaction.
REQ-008 SCAN_REQ SHALL drive o_register_address=8'h00 and o_device_address equal to the probe address.
REQ-009 READ_REQ SHALL drive o_register_address equal to the current entry of the package byte list (2,3,4,5,7,8,10,11,12) and o_device_address equal to o_spd_address.
REQ-010 A WAIT state SHALL complete only after i_busy has been seen high at least once since entry and is then seen low; i_slave_nack is sampled on the completing cycle.
REQ-011 On SCAN_WAIT completion with NACK, if the probe address is below SCAN_LAST the block SHALL increment it and go to SCAN_REQ; otherwise it SHALL go to ERROR.
REQ-012 On SCAN_WAIT completion with ACK, the block SHALL latch o_spd_address equal to the probe address, set the list index to 0, and go to READ_REQ.
REQ-013 On READ_WAIT completion with ACK, the next cycle SHALL pulse o_byte_valid with o_byte_data=i_miso_data and o_byte_index equal to the list entry, then advance the index. After the 9th entry it SHALL go to DONE; otherwise it SHALL go to READ_REQ.
REQ-014 On READ_WAIT completion with NACK, behaviour SHALL follow REQ-020 and REQ-021.
REQ-015 A cycle counter SHALL clear on entry to each WAIT state. If it reaches TIMEOUT_CYCLES-1 before completion, the block SHALL go to ERROR. The counter width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-016 DONE SHALL hold o_done=1 and ERROR SHALL hold o_error=1 until the next i_start or reset; o_done and o_error SHALL never both be 1.

Reset
REQ-017 When i_rst=1 at a rising edge, the block SHALL enter IDLE, including mid-transaction, with no further o_enable pulse.
REQ-018 On reset, o_enable, o_read_write, o_byte_valid, o_done and o_error SHALL be 0; o_register_address, o_byte_index and o_byte_data SHALL be 8'h00; o_device_address and o_spd_address SHALL be 7'h00.
REQ-019 On reset, the timeout counter, list index and retry counter SHALL be 0.

Configuration
REQ-020 With macro SPD_SEQ_RETRY_EN defined, a NACK in READ_WAIT SHALL re-issue the same byte via READ_REQ up to 3 times, with a 2-bit retry counter cleared per byte; a 4th NACK SHALL go to ERROR.
REQ-021 With SPD_SEQ_RETRY_EN undefined, a NACK in READ_WAIT SHALL go directly to ERROR, and no retry logic SHALL be present.

Structure
REQ-022 Package spd_pkg SHALL hold the state enumeration, the 9-entry SPD byte-list constant, SPD_LIST_LEN=9 and MAX_RETRIES=3.
REQ-023 The timeout counter SHALL be the sole sub-module, spd_timeout_ctr, with inputs clear and enable and output expired; all other logic SHALL be in one FSM.

Verification
REQ-024 Model ACKs only at 7'h52, i_start pulsed -> probes 50, 51 and 52; o_spd_address=7'h52; nine o_byte_valid pulses with indexes 2,3,4,5,7,8,10,11,12; then o_done=1.
REQ-025 All addresses NACK -> eight probes (50 to 57), then o_error=1 and o_done=0.
REQ-026 Model never raises i_busy, TIMEOUT_CYCLES=100 -> o_error=1 exactly 100 cycles after WAIT entry.
REQ-027 NACK once on byte 4 -> with SPD_SEQ_RETRY_EN, byte 4 is re-read and the sequence completes with o_done=1; without the macro, o_error=1 and only 2 bytes are reported.
REQ-028 i_rst asserted in the middle of READ_WAIT -> next cycle all outputs hold their reset values; a following i_start restarts from 7'h50.
REQ-029 i_start pulsed during SCAN_WAIT -> ignored, and the probe sequence is unchanged.
